uart_rx_frontend: RTL and testbench
===================================

// Module: uart_rx_frontend
// PURPOSE
// - Serial receive front-end for the UART tile, directly upstream of the UART IO engine.
// - Samples the external uart_master_tx line at 16x oversampling and checks start/stop (optional parity).
// - Pushes received bytes into a small first-word-fall-through FIFO.
// - Offers the FIFO head to the IO engine on a valid/ready byte interface; the IO engine turns bytes into C2F ring requests.
// PARAMETERS
// - BAUD_DIV    16'd27  QClk cycles per oversample tick (bit time = 16*BAUD_DIV clocks); legal 2..65535
// - FIFO_DEPTH  8       byte FIFO entries; power of two, 2..64
// - PARITY_ODD  0       parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd
// PORTS
// - QClk          in   1                   tile clock
// - RstQnnnH      in   1                   reset, synchronous, active-low
// - uart_rx_in    in   1                   async serial line, idle high (tile pin uart_master_tx)
// - RxByteValid   out  1                   FIFO not empty
// - RxByteData    out  8                   FIFO head byte
// - RxByteReady   in   1                   consumer pops the head when RxByteValid && RxByteReady
// - RxFifoCount   out  $clog2(FIFO_DEPTH)+1  current occupancy
// - RxFramingErr  out  1                   1-cycle pulse: stop bit sampled low
// - RxParityErr   out  1                   1-cycle pulse: parity mismatch
// - RxOverrun     out  1                   1-cycle pulse: byte dropped because FIFO full
// BEHAVIOUR
// - Reset (RstQnnnH==0 at a QClk edge):
//   - FSM -> IDLE; all counters and FIFO pointers -> 0.
//   - Both synchronizer flops and the previous-line register -> 1.
//   - All outputs 0; RxFifoCount = 0.
//   - Reset mid-frame discards the partial byte and all FIFO contents.
// - Synchronizer: 2 flops on uart_rx_in; all logic uses the synchronized value rx_s.
// - Tick generator:
//   - Counter runs 0..BAUD_DIV-1 and wraps; tick = (count == BAUD_DIV-1).
//   - Counter is cleared on the IDLE->START transition so sampling is aligned to the start edge.
// - Sample counter: 4 bits, advances on tick, wraps 15->0; mid-bit = (sample counter == 7 && tick).
// - FSM states:
//   - IDLE: on falling edge of rx_s (previous 1, current 0) -> START. A line held low (break) never restarts a frame.
//   - START: at mid-bit, rx_s==0 -> DATA with bit index 0; rx_s==1 -> IDLE (glitch, no error).
//   - DATA:
//     - At each mid-bit, shift rx_s in LSB-first.
//     - After bit index 7 -> PARITY if UART_RX_PARITY_EN is defined, else -> STOP.
//   - PARITY: at mid-bit, compare rx_s with the expected parity of the data bits; record mismatch; -> STOP.
//   - STOP: at mid-bit -> IDLE in that cycle (half-bit early, for resync). Then:
//     - rx_s==0: RxFramingErr pulse, byte dropped.
//     - else parity mismatch: RxParityErr pulse, byte dropped.
//     - else FIFO push.
//     - Framing and parity errors are mutually exclusive per frame; framing takes priority.
// - FIFO:
//   - A push becomes visible as RxByteValid on the cycle after the stop mid-bit sample.
//   - Push while full with no pop in the same cycle: byte dropped, RxOverrun pulse, contents unchanged.
//   - Push while full with a simultaneous pop: both accepted, count unchanged, no overrun.
//   - Pop while empty: ignored.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - RxByteData is stable while RxByteValid && !RxByteReady.
//   - RxByteData is don't-care when empty; it is driven 0.
// CONFIGURATION
// - UART_RX_PARITY_EN defined:
//   - 11-bit frame (start, 8 data, parity, stop); PARITY state present; PARITY_ODD selects the sense.
// - UART_RX_PARITY_EN undefined:
//   - 10-bit frame (8N1); PARITY state not built; RxParityErr tied 0; PARITY_ODD unused.
// TESTING (BAUD_DIV=4 -> bit = 64 clk; FIFO_DEPTH=4)
// - Clean receive: send 8N1 bytes 0xA5 then 0x3C, RxByteReady=1 -> two pops in order (0xA5, 0x3C); no error pulses.
// - Glitch: line low for 20 clk, then high -> no byte, no error; FSM returns to IDLE; the next 0x55 frame is received correctly.
// - Framing: 0x81 with stop bit low -> exactly one RxFramingErr pulse, FIFO count stays 0; line held low 300 clk -> no new frame until the line rises and falls again.
// - Overrun: RxByteReady=0, send 5 bytes 0x01..0x05 -> count saturates at 4, one RxOverrun pulse on the 5th; pops return 0x01..0x04.
// - Full + simultaneous pop: FIFO full; assert RxByteReady for one cycle coincident with the 5th stop mid-bit -> no overrun, count stays 4, new byte at the tail.
// - Reset mid-frame: drop RstQnnnH during DATA bit 3 with 2 bytes buffered -> next cycle all outputs 0, count 0; the next full frame 0xC3 is received. With UART_RX_PARITY_EN and even parity, 0x07 sent with parity bit 0 -> one RxParityErr pulse, no push.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x-oversampled UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to build the 11-bit frame with a parity check; otherwise the frame is 8N1.
module uart_rx_frontend #(
   parameter logic [15:0] BAUD_DIV   = 16'd27,
   parameter int          FIFO_DEPTH = 8,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                        QClk,
   input  logic                        RstQnnnH,
   input  logic                        uart_rx_in,
   output logic                        RxByteValid,
   output logic [7:0]                  RxByteData,
   input  logic                        RxByteReady,
   output logic [$clog2(FIFO_DEPTH):0] RxFifoCount,
   output logic                        RxFramingErr,
   output logic                        RxParityErr,
   output logic                        RxOverrun
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   logic          sync1_q, sync2_q, prevRx_q, rxS;
   logic [15:0]   baudCnt_q;
   logic [3:0]    sampleCnt_q;
   logic          tick, midBit;
   state_t        state_q, state_d;
   logic [2:0]    bitIdx_q, bitIdx_d;
   logic [7:0]    shift_q, shift_d;
   logic          frameStart, pushReq;
   logic          framingErr_q, framingErr_d;
   logic          overrun_q, overrun_d;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wrPtr_q, rdPtr_q;
   logic [CW-1:0] count_q, count_d;
   logic          pop, full, pushOk;

   assign rxS    = sync2_q;
   assign tick   = (baudCnt_q == BAUD_DIV - 16'd1);
   assign midBit = tick && (sampleCnt_q == 4'd7);

   always_ff @(posedge QClk) begin
      if (!RstQnnnH) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         prevRx_q <= 1'b1;
      end else begin
         sync1_q  <= uart_rx_in;
         sync2_q  <= sync1_q;
         prevRx_q <= sync2_q;
      end
   end

   // Both counters restart on the detected start edge so mid-bit lands half a bit later.
   always_ff @(posedge QClk) begin
      if (!RstQnnnH || frameStart) begin
         baudCnt_q   <= '0;
         sampleCnt_q <= '0;
      end else if (tick) begin
         baudCnt_q   <= '0;
         sampleCnt_q <= sampleCnt_q + 4'd1;
      end else begin
         baudCnt_q   <= baudCnt_q + 16'd1;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic parErr_q, parErr_d;
   logic parityErr_q, parityErr_d;

   always_ff @(posedge QClk) begin
      if (!RstQnnnH) begin
         parErr_q    <= 1'b0;
         parityErr_q <= 1'b0;
      end else begin
         parErr_q    <= parErr_d;
         parityErr_q <= parityErr_d;
      end
   end
   assign RxParityErr = parityErr_q;
`else
   logic unusedParityOdd;
   assign unusedParityOdd = PARITY_ODD;
   assign RxParityErr     = 1'b0;
`endif

   always_ff @(posedge QClk) begin
      if (!RstQnnnH) begin
         state_q      <= IDLE;
         bitIdx_q     <= '0;
         shift_q      <= '0;
         framingErr_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bitIdx_q     <= bitIdx_d;
         shift_q      <= shift_d;
         framingErr_q <= framingErr_d;
         overrun_q    <= overrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bitIdx_d     = bitIdx_q;
      shift_d      = shift_q;
      frameStart   = 1'b0;
      pushReq      = 1'b0;
      framingErr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parErr_d     = parErr_q;
      parityErr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (prevRx_q && !rxS) begin
               state_d    = START;
               frameStart = 1'b1;
`ifdef UART_RX_PARITY_EN
               parErr_d   = 1'b0;
`endif
            end
         end
         START: begin
            if (midBit) begin
               state_d  = rxS ? IDLE : DATA;
               bitIdx_d = '0;
            end
         end
         DATA: begin
            if (midBit) begin
               shift_d  = {rxS, shift_q[7:1]};
               bitIdx_d = bitIdx_q + 3'd1;
               if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (midBit) begin
               parErr_d = (rxS != ((^shift_q) ^ PARITY_ODD));
               state_d  = STOP;
            end
         end
`endif
         STOP: begin
            // Leave at the stop mid-bit so the next start edge is never missed.
            if (midBit) begin
               state_d = IDLE;
               if (!rxS) begin
                  framingErr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (parErr_q) begin
                  parityErr_d = 1'b1;
`endif
               end else begin
                  pushReq = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   assign pop    = (count_q != '0) && RxByteReady;
   assign full   = (count_q == CW'(FIFO_DEPTH));
   assign pushOk = pushReq && (!full || pop);

   always_comb begin
      overrun_d = pushReq && full && !pop;
      count_d   = count_q;
      if (pushOk && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!pushOk && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge QClk) begin
      if (!RstQnnnH) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (pushOk) begin
            wrPtr_q <= wrPtr_q + PW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge QClk) begin
      if (pushOk) begin
         mem[wrPtr_q] <= shift_q;
      end
   end

   assign RxByteValid  = (count_q != '0);
   assign RxByteData   = RxByteValid ? mem[rdPtr_q] : 8'h00;
   assign RxFifoCount  = count_q;
   assign RxFramingErr = framingErr_q;
   assign RxOverrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: randomized serial frames against a byte-queue reference model.
// Parity scenarios are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frontend;
   localparam logic [15:0] BAUD_DIV   = 16'd4;
   localparam int          FIFO_DEPTH = 4;
   localparam bit          PARITY_ODD = 1'b0;
   localparam int          BIT        = 16 * 4;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       line = 1'b1;
   logic       ready = 1'b0;
   logic       RxByteValid;
   logic [7:0] RxByteData;
   logic [2:0] RxFifoCount;
   logic       RxFramingErr, RxParityErr, RxOverrun;

   int compared = 0;
   int mismatched = 0;

   logic [7:0] gotQ[$];
   logic [7:0] expQ[$];
   int ferrCnt = 0;
   int perrCnt = 0;
   int ovrCnt = 0;
   int maxCount = 0;

   uart_rx_frontend #(
      .BAUD_DIV(BAUD_DIV),
      .FIFO_DEPTH(FIFO_DEPTH),
      .PARITY_ODD(PARITY_ODD)
   ) dut (
      .QClk(clk),
      .RstQnnnH(rstN),
      .uart_rx_in(line),
      .RxByteValid(RxByteValid),
      .RxByteData(RxByteData),
      .RxByteReady(ready),
      .RxFifoCount(RxFifoCount),
      .RxFramingErr(RxFramingErr),
      .RxParityErr(RxParityErr),
      .RxOverrun(RxOverrun)
   );

   always #5 clk = ~clk;

   // Observe consumer handshakes and error pulses away from the active edge.
   always @(negedge clk) begin
      if (rstN) begin
         if (RxByteValid && ready) gotQ.push_back(RxByteData);
         if (RxFramingErr) ferrCnt++;
         if (RxParityErr) perrCnt++;
         if (RxOverrun) ovrCnt++;
         if (int'(RxFifoCount) > maxCount) maxCount = int'(RxFifoCount);
      end
   end

   initial begin
      repeat (200000) @(posedge clk);
      $display("[TB] FAIL watchdog: run did not finish, got 0 required 1");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clearObs();
      gotQ.delete();
      expQ.delete();
      ferrCnt = 0;
      perrCnt = 0;
      ovrCnt = 0;
      maxCount = 0;
   endtask

   // Drives one frame; the line is left at the stop-bit level afterwards.
   task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic parFlip);
      @(posedge clk); #1;
      line = 1'b0;
      idle(BIT);
      for (int i = 0; i < 8; i++) begin
         line = d[i];
         idle(BIT);
      end
`ifdef UART_RX_PARITY_EN
      line = (^d) ^ PARITY_ODD ^ parFlip;
      idle(BIT);
`else
      if (parFlip) line = 1'b1;
`endif
      line = stopBit;
      idle(BIT);
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      line = 1'b1;
      ready = 1'b0;
      idle(5);
      compared++; if (RxByteValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b required 0", RxByteValid); end
      compared++; if (RxByteData !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data got %h required 00", RxByteData); end
      compared++; if (RxFifoCount !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count got %0d required 0", RxFifoCount); end
      compared++; if ({RxFramingErr, RxParityErr, RxOverrun} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_errs got %b required 000", {RxFramingErr, RxParityErr, RxOverrun}); end
      rstN = 1'b1;
      idle(10);
   endtask

   task automatic test_clean();
      logic [7:0] b;
      clearObs();
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b = (i == 0) ? 8'hA5 : (i == 1) ? 8'h3C : 8'($urandom_range(0, 255));
         expQ.push_back(b);
         sendFrame(b, 1'b1, 1'b0);
      end
      idle(10);
      compared++; if (gotQ.size() !== expQ.size()) begin mismatched++; $display("[TB] FAIL clean_count got %0d required %0d", gotQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
         compared++; if (gotQ[i] !== expQ[i]) begin mismatched++; $display("[TB] FAIL clean_byte%0d got %h required %h", i, gotQ[i], expQ[i]); end
      end
      compared++; if (ferrCnt + perrCnt + ovrCnt !== 0) begin mismatched++; $display("[TB] FAIL clean_errs got %0d required 0", ferrCnt + perrCnt + ovrCnt); end
   endtask

   task automatic test_glitch();
      int len;
      logic [7:0] b;
      for (int k = 0; k < 2; k++) begin
         clearObs();
         ready = 1'b1;
         len = (k == 0) ? 20 : int'($urandom_range(4, 24));
         @(posedge clk); #1;
         line = 1'b0;
         idle(len);
         line = 1'b1;
         idle(100);
         compared++; if (gotQ.size() + ferrCnt + perrCnt !== 0) begin mismatched++; $display("[TB] FAIL glitch_quiet len %0d got %0d events required 0", len, gotQ.size() + ferrCnt + perrCnt); end
         b = (k == 0) ? 8'h55 : 8'($urandom_range(0, 255));
         sendFrame(b, 1'b1, 1'b0);
         idle(10);
         compared++; if (gotQ.size() !== 1 || gotQ[0] !== b) begin mismatched++; $display("[TB] FAIL glitch_next got %0d bytes (first %h) required 1 byte %h", gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 8'h00, b); end
      end
   endtask

   task automatic test_framing();
      logic [7:0] b;
      clearObs();
      ready = 1'b1;
      sendFrame(8'h81, 1'b0, 1'b0);
      idle(300);
      compared++; if (ferrCnt !== 1) begin mismatched++; $display("[TB] FAIL framing_pulses got %0d required 1", ferrCnt); end
      compared++; if (RxFifoCount !== 3'd0 || gotQ.size() !== 0) begin mismatched++; $display("[TB] FAIL framing_nopush got count %0d bytes %0d required 0 0", RxFifoCount, gotQ.size()); end
      line = 1'b1;
      idle(20);
      compared++; if (ferrCnt !== 1) begin mismatched++; $display("[TB] FAIL framing_break got %0d pulses required 1", ferrCnt); end
      b = 8'($urandom_range(0, 255));
      sendFrame(b, 1'b1, 1'b0);
      idle(10);
      compared++; if (gotQ.size() !== 1 || gotQ[0] !== b) begin mismatched++; $display("[TB] FAIL framing_recover got %0d bytes (first %h) required 1 byte %h", gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 8'h00, b); end
   endtask

   task automatic test_overrun();
      int expOvr;
      clearObs();
      ready = 1'b0;
      expOvr = 0;
      for (int i = 1; i <= 5; i++) begin
         if (expQ.size() < FIFO_DEPTH) expQ.push_back(8'(i));
         else expOvr++;
         sendFrame(8'(i), 1'b1, 1'b0);
      end
      idle(10);
      compared++; if (int'(RxFifoCount) !== expQ.size()) begin mismatched++; $display("[TB] FAIL overrun_count got %0d required %0d", RxFifoCount, expQ.size()); end
      compared++; if (maxCount !== FIFO_DEPTH) begin mismatched++; $display("[TB] FAIL overrun_max got %0d required %0d", maxCount, FIFO_DEPTH); end
      compared++; if (ovrCnt !== expOvr) begin mismatched++; $display("[TB] FAIL overrun_pulses got %0d required %0d", ovrCnt, expOvr); end
      ready = 1'b1;
      idle(10);
      compared++; if (gotQ.size() !== expQ.size()) begin mismatched++; $display("[TB] FAIL overrun_drain got %0d required %0d", gotQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
         compared++; if (gotQ[i] !== expQ[i]) begin mismatched++; $display("[TB] FAIL overrun_byte%0d got %h required %h", i, gotQ[i], expQ[i]); end
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] b;
      clearObs();
      ready = 1'b0;
      for (int i = 0; i < 5; i++) expQ.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 4; i++) sendFrame(expQ[i], 1'b1, 1'b0);
      idle(5);
      compared++; if (RxFifoCount !== 3'd4) begin mismatched++; $display("[TB] FAIL fullpop_fill got %0d required 4", RxFifoCount); end
      b = expQ[4];
      fork
         sendFrame(b, 1'b1, 1'b0);
         begin
            @(posedge clk);
            repeat (610) @(posedge clk);
            #1 ready = 1'b1;
            @(posedge clk);
            #1 ready = 1'b0;
         end
      join
      idle(5);
      compared++; if (RxFifoCount !== 3'd4) begin mismatched++; $display("[TB] FAIL fullpop_count got %0d required 4", RxFifoCount); end
      compared++; if (ovrCnt !== 0) begin mismatched++; $display("[TB] FAIL fullpop_overrun got %0d required 0", ovrCnt); end
      ready = 1'b1;
      idle(10);
      compared++; if (gotQ.size() !== expQ.size()) begin mismatched++; $display("[TB] FAIL fullpop_drain got %0d required %0d", gotQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
         compared++; if (gotQ[i] !== expQ[i]) begin mismatched++; $display("[TB] FAIL fullpop_byte%0d got %h required %h", i, gotQ[i], expQ[i]); end
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      clearObs();
      ready = 1'b0;
      for (int i = 0; i < 2; i++) sendFrame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      idle(5);
      compared++; if (RxFifoCount !== 3'd2) begin mismatched++; $display("[TB] FAIL midreset_buffered got %0d required 2", RxFifoCount); end
      d = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      line = 1'b0;
      idle(BIT);
      for (int i = 0; i < 3; i++) begin
         line = d[i];
         idle(BIT);
      end
      line = d[3];
      idle(BIT / 2);
      rstN = 1'b0;
      idle(1);
      compared++; if (RxByteValid !== 1'b0 || RxByteData !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_head got valid %b data %h required 0 00", RxByteValid, RxByteData); end
      compared++; if (RxFifoCount !== 3'd0) begin mismatched++; $display("[TB] FAIL midreset_count got %0d required 0", RxFifoCount); end
      compared++; if ({RxFramingErr, RxParityErr, RxOverrun} !== 3'b000) begin mismatched++; $display("[TB] FAIL midreset_errs got %b required 000", {RxFramingErr, RxParityErr, RxOverrun}); end
      rstN = 1'b1;
      line = 1'b1;
      idle(20);
      ready = 1'b1;
      sendFrame(8'hC3, 1'b1, 1'b0);
      idle(10);
      compared++; if (gotQ.size() !== 1 || gotQ[0] !== 8'hC3) begin mismatched++; $display("[TB] FAIL midreset_next got %0d bytes (first %h) required 1 byte c3", gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 8'h00); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      logic [7:0] b;
      clearObs();
      ready = 1'b1;
      sendFrame(8'h07, 1'b1, 1'b1);
      idle(10);
      compared++; if (perrCnt !== 1 || ferrCnt !== 0) begin mismatched++; $display("[TB] FAIL parity_pulse got parity %0d framing %0d required 1 0", perrCnt, ferrCnt); end
      compared++; if (gotQ.size() !== 0) begin mismatched++; $display("[TB] FAIL parity_nopush got %0d required 0", gotQ.size()); end
      b = 8'($urandom_range(0, 255));
      sendFrame(b, 1'b1, 1'b0);
      idle(10);
      compared++; if (gotQ.size() !== 1 || gotQ[0] !== b || perrCnt !== 1) begin mismatched++; $display("[TB] FAIL parity_good got %0d bytes (first %h) perr %0d required 1 byte %h perr 1", gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 8'h00, perrCnt, b); end
   endtask
`endif

   initial begin
      test_reset();
      test_clean();
      test_glitch();
      test_framing();
      test_overrun();
      test_full_pop();
      test_reset_midframe();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
